// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its FIFOs.
package ifetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;
   localparam int PC_W    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/response channel plus the instruction handshake toward the datapath.
interface ifetch_if
   import ifetch_pkg::*;
#(
   parameter int ADDR_W = 32
);

   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instruccion;
   logic [ADDR_W-1:0]  instr_pc;

   modport master (
      output imem_req_valid, imem_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output instr_valid, instruccion, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  instr_valid, instruccion, instr_pc,
      output instr_ready
   );

endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries with synchronous clear; push on a full FIFO is only
// accepted together with a pop, pop on an empty FIFO is ignored.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  fetch_entry_t     din,
   output fetch_entry_t     dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != DEPTH_C) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Clear wins over any push/pop in the same cycle.
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, issues credit-limited word requests and buffers
// returned words for the datapath. Define IFETCH_STATS_EN to add fetch/stall counters.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   ifetch_if.master          bus
`ifdef IFETCH_STATS_EN
   ,
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_count
`endif
);

   localparam int                CNT_W    = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(BUF_DEPTH);
   localparam logic [ADDR_W-1:0] ALIGN_MK = ~ADDR_W'(3);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]  occupancy, outstanding, inflight_after;
   logic [CNT_W:0]    credit_used;
   logic              buf_full, buf_empty, pcq_full, pcq_empty;
   fetch_entry_t      buf_din, buf_head, pcq_din, pcq_head;
   logic              flush, req_valid, req_fire, rsp_in, rsp_accept, rsp_drop, pop_ok;

   always_comb begin
      flush       = redirect_valid;
      // Slots still owed to stale responses count against the buffer like live ones.
      credit_used = {1'b0, occupancy} + {1'b0, outstanding} + {1'b0, drop_cnt_q};
      req_valid   = (state_q == FETCH) && en && !flush && (credit_used < DEPTH_C)
                    && !pcq_full && !buf_full;
      req_fire    = req_valid && bus.imem_req_ready;
      rsp_drop    = bus.imem_rsp_valid && (drop_cnt_q != '0);
      rsp_accept  = bus.imem_rsp_valid && (drop_cnt_q == '0) && !pcq_empty;
      rsp_in      = rsp_accept || rsp_drop;
      pop_ok      = !buf_empty && bus.instr_ready && !flush;

      pcq_din.pc    = PC_W'(pc_q);
      pcq_din.instr = '0;
      buf_din       = pcq_head;
      buf_din.instr = bus.imem_rsp_data;

      inflight_after = outstanding + drop_cnt_q - CNT_W'(rsp_in);

      pc_d       = req_fire ? pc_q + ADDR_W'(PC_STEP) : pc_q;
      drop_cnt_d = drop_cnt_q - CNT_W'(rsp_drop);
      state_d    = state_q;
      if (flush) begin
         pc_d       = redirect_pc & ALIGN_MK;
         drop_cnt_d = inflight_after;
         if (!(state_q == IDLE && !en)) begin
            state_d = (inflight_after != '0) ? FLUSH : FETCH;
         end
      end else begin
         case (state_q)
            IDLE:    if (en) state_d = FETCH;
            FETCH:   if (!en && outstanding == '0) state_d = IDLE;
            FLUSH: begin
               if (!en)                     state_d = IDLE;
               else if (drop_cnt_d == '0)   state_d = FETCH;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Request PCs wait here until their word returns; its count is the outstanding total.
   ifetch_fifo #(.DEPTH(BUF_DEPTH)) u_pc_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .push  (req_fire),
      .pop   (rsp_accept),
      .din   (pcq_din),
      .dout  (pcq_head),
      .full  (pcq_full),
      .empty (pcq_empty),
      .count (outstanding)
   );

   ifetch_fifo #(.DEPTH(BUF_DEPTH)) u_instr_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .push  (rsp_accept),
      .pop   (pop_ok),
      .din   (buf_din),
      .dout  (buf_head),
      .full  (buf_full),
      .empty (buf_empty),
      .count (occupancy)
   );

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_addr      = pc_q;
   assign bus.instr_valid    = !buf_empty;
   assign bus.instruccion    = buf_empty ? '0 : buf_head.instr;
   assign bus.instr_pc       = buf_empty ? '0 : ADDR_W'(buf_head.pc);

`ifdef IFETCH_STATS_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] stall_count_q, stall_count_d;

   always_comb begin
      fetch_count_d = fetch_count_q;
      stall_count_d = stall_count_q;
      if (pop_ok && fetch_count_q != '1) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
      if (bus.instr_ready && buf_empty && (state_q == FETCH || state_q == FLUSH)
          && stall_count_q != '1) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a memory model answers requests, the stimulus pushes the
// expected delivered words, and a monitor compares every pop toward the datapath.
module tb_ifetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct packed {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   ifetch_if #(.ADDR_W(32)) bus ();

`ifdef IFETCH_STATS_EN
   logic [31:0] fetch_count, stall_count;
`endif

   ifetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus.master)
`ifdef IFETCH_STATS_EN
      ,
      .fetch_count    (fetch_count),
      .stall_count    (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int    checks   = 0;
   int    failures = 0;
   int    pops     = 0;
   int    req_count = 0;
   int    cyc      = 0;
   int    last_due = 0;
   int    mem_lat  = 1;
   bit    mem_hold = 1'b0;
   bit    mem_rand = 1'b0;
   exp_t  exp_q[$];
   mreq_t mq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      logic [31:0] pc;
      for (int i = 0; i < n; i++) begin
         pc = start + 32'(4 * i);
         exp_q.push_back('{pc: pc, instr: pc ^ 32'hA5A5_0000});
      end
   endtask

   task automatic consume(input int n);
      int target;
      int waited;
      target = pops + n;
      waited = 0;
      bus.instr_ready = 1'b1;
      while (pops < target && waited < 400) begin
         @(posedge clk);
         #1;
         waited++;
      end
      bus.instr_ready = 1'b0;
      chk("consume_count", 32'(pops), 32'(target));
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      redirect_pc    = target;
      redirect_valid = 1'b1;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
   endtask

   // Memory model: in-order responses, data = addr ^ A5A5_0000, optional hold and random timing.
   initial begin : mem_model
      int lat;
      int due;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mq.delete();
         end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            lat = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: bus.imem_addr, due: due});
            req_count++;
         end
         @(posedge clk);
         #1;
         cyc++;
         bus.imem_rsp_valid = 1'b0;
         if (!rst_n) begin
            mq.delete();
         end else if (!mem_hold && mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mq[0].addr ^ 32'hA5A5_0000;
            void'(mq.pop_front());
         end
         bus.imem_req_ready = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.instr_valid && bus.instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_instr: got pc %h instr %h expected none", bus.instr_pc,
                        bus.instruccion);
            end else begin
               e = exp_q.pop_front();
               chk("instr_pc", bus.instr_pc, e.pc);
               chk("instruccion", bus.instruccion, e.instr);
            end
            pops++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int found;
      rst_n           = 1'b1;
      en              = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      bus.instr_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instruccion", bus.instruccion, 32'd0);
      chk("rst_instr_pc", bus.instr_pc, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_no_req", 32'(bus.imem_req_valid), 32'd0);
      en = 1'b1;

      // Streaming from RESET_PC with latency 1.
      push_seq(32'h0, 8);
      consume(8);

      // Backpressure: only BUF_DEPTH more requests, head held.
      repeat (10) @(posedge clk);
      #1;
      chk("bp_req_total", 32'(req_count), 32'd10);
      chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("bp_head_pc", bus.instr_pc, 32'h20);
      chk("bp_head_instr", bus.instruccion, 32'h20 ^ 32'hA5A5_0000);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_head_stable", bus.instr_pc, 32'h20);
      chk("bp_req_total2", 32'(req_count), 32'd10);

      // Redirect with two requests stuck in memory.
      mem_hold = 1'b1;
      push_seq(32'h20, 2);
      consume(2);
      repeat (4) @(posedge clk);
      #1;
      chk("hold_req_total", 32'(req_count), 32'd12);
      chk("hold_req_valid", 32'(bus.imem_req_valid), 32'd0);
      pulse_redirect(32'h0000_0103);
      chk("redir_addr", bus.imem_addr, 32'h100);
      chk("redir_flush_noreq", 32'(bus.imem_req_valid), 32'd0);
      mem_hold = 1'b0;
      push_seq(32'h100, 4);
      consume(4);

      // Flush of a full buffer, then redirect coinciding with a response and a pop.
      repeat (10) @(posedge clk);
      #1;
      chk("full_valid", 32'(bus.instr_valid), 32'd1);
      pulse_redirect(32'h140);
      chk("full_flushed", 32'(bus.instr_valid), 32'd0);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         @(posedge clk);
         #2;
         if (bus.imem_rsp_valid && bus.instr_valid) found = 1;
      end
      chk("rsp_pop_setup", 32'(found), 32'd1);
      bus.instr_ready = 1'b1;
      pulse_redirect(32'h200);
      bus.instr_ready = 1'b0;
      chk("rsp_pop_flushed", 32'(bus.instr_valid), 32'd0);
      push_seq(32'h200, 4);
      consume(4);

      // Random ready and latency across the address wrap.
      mem_rand = 1'b1;
      pulse_redirect(32'hFFFF_FFF0);
      push_seq(32'hFFFF_FFF0, 10);
      consume(10);
      mem_rand = 1'b0;

      // Asynchronous reset mid-stream.
      repeat (6) @(posedge clk);
      #1;
      chk("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("async_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("async_instruccion", bus.instruccion, 32'd0);
      chk("async_instr_pc", bus.instr_pc, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      push_seq(32'h0, 4);
      consume(4);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle datapath. It drives the datapath's 32-bit instruction input.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words in a small FIFO and presents them to the datapath with a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
BUF_DEPTH, 2, instruction buffer entries (power of 2, >=2)
ADDR_W, 32, PC/address width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  fetch enable; low = no new requests issued
redirect_valid  input  1  one-cycle pulse: load new PC, flush
redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
imem_req_valid  output  1  request to instruction memory
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  ADDR_W  word-aligned request address (= PC)
imem_rsp_valid  input  1  response word valid (in order, latency >=1, no backpressure)
imem_rsp_data  input  32  response instruction word
instr_valid  output  1  buffer head valid toward datapath
instr_ready  input  1  datapath consumes head this cycle
instruccion  output  32  head instruction word (feeds datapath instruccion)
instr_pc  output  ADDR_W  PC of head instruction

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - pc=RESET_PC; buffer empty; outstanding=0; drop_cnt=0; state=IDLE.
  - imem_req_valid=0, instr_valid=0, instruccion=0, instr_pc=0.
- States:
  - IDLE: no requests. Go to FETCH when en=1.
  - FETCH: normal operation. Go to IDLE when en=0 and outstanding=0.
  - FLUSH: discarding stale responses while drop_cnt>0. Go to FETCH when drop_cnt reaches 0, or to IDLE if en=0.
- Credit rule: imem_req_valid = (state==FETCH) && en && !redirect_valid && (occupancy + outstanding < BUF_DEPTH). Every response therefore has a guaranteed buffer slot, so there is no response overflow.
- Request: the handshake fires when imem_req_valid && imem_req_ready. On fire: imem_addr=pc, then pc<=pc+4 (wraps mod 2^ADDR_W), and outstanding+1. The request PC is pushed into a PC side-queue of depth BUF_DEPTH.
- imem_req_valid may deassert without a handshake only due to redirect_valid or en falling. Memory must tolerate this.
- Response: imem_rsp_valid with drop_cnt=0 pushes {pc_queue head, imem_rsp_data} into the buffer, and outstanding-1. With drop_cnt>0 the word is discarded and drop_cnt-1.
- Output: instr_valid = buffer non-empty; instruccion/instr_pc = head. Pop on instr_valid && instr_ready. Head is stable while instr_valid && !instr_ready.
- Latency: response word is visible on instruccion the cycle after imem_rsp_valid (registered buffer, no bypass).
- Simultaneous push and pop on a full buffer: legal, occupancy unchanged. Pop on empty is ignored.
- Redirect (highest priority, any state except IDLE-with-en=0, where pc is still loaded):
  - Buffer and PC queue are cleared; instr_valid=0 next cycle.
  - pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
  - drop_cnt <= outstanding remaining after this cycle's response (if one arrived, it is dropped this cycle).
  - outstanding is cleared logically: drop_cnt carries those slots for credit purposes.
  - state <= FLUSH if drop_cnt_next>0, else FETCH.
  - A pop in the same cycle as a redirect has no effect beyond the flush.
- Reset mid-operation: all state cleared immediately. In-flight memory responses after reset release are not expected; memory is reset by the same rst_n.

Optional Feature:
IFETCH_STATS_EN:
- Defined: adds outputs fetch_count[31:0] (pops to datapath) and stall_count[31:0] (cycles with instr_ready=1 && instr_valid=0 in FETCH/FLUSH). Both reset to 0, saturate at 32'hFFFF_FFFF, and are unaffected by redirect.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ifetch_pkg holds:
  - typedef fetch_state_t {IDLE,FETCH,FLUSH}
  - localparam INSTR_W=32
  - localparam PC_STEP=4
  - typedef fetch_entry_t {pc, instr}
- One sub-module, ifetch_fifo: parameterized synchronous FIFO of fetch_entry_t with push/pop/full/empty/count. It is instantiated once for the buffer; the PC side-queue uses the same module.

Test Plan:
- Reset, en=1, imem_req_ready=1, memory latency 1 returning addr^32'hA5A5_0000 -> instr_pc 0,4,8,... with matching instruccion, one per cycle once steady.
- instr_ready=0 for 10 cycles -> exactly BUF_DEPTH+0 outstanding requests issued total (occupancy+outstanding<=2), no request after that, head stable.
- Redirect to 32'h0000_0103 with 2 requests outstanding -> pc=32'h100, 2 responses dropped, first delivered instr_pc=32'h100.
- Redirect in same cycle as a response and a pop -> response dropped, buffer empty next cycle, no stale word ever delivered.
- imem_req_ready toggling randomly, latency 1-3 -> in-order, gap-free instr_pc sequence; pc wrap from 32'hFFFF_FFFC to 0 is delivered correctly.
- Assert rst_n low mid-stream -> all outputs 0 asynchronously; first fetch after release at RESET_PC.
